sap_cpu_param: RTL and testbench

// Parametrised successor to the SAP-1 top level: an accumulator CPU with a single

---
 rtl/sap_cpu_param.sv | 247 ++++++++++++++++++++++++
 tb/tb_sap_cpu_param.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_cpu_param.sv
// Parametrised SAP-style accumulator CPU: single internal bus, built-in RAM,
// fixed five-state controller, output register, Z/C flags and a halt latch.
module sap_cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] bus,
  output logic [1:0]        flags,
  output logic              halted
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] mar_reg;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] out_reg;
  logic              c_reg;
  logic              z_reg;
  logic              halted_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] pc_ext;
  logic [DATA_W-1:0] addr_ext;

  assign opcode   = ir_reg[DATA_W-1 -: 4];
  assign op_addr  = ir_reg[ADDR_W-1:0];
  assign ram_q    = mem[mar_reg];
  assign pc_ext   = DATA_W'(pc_reg);
  assign addr_ext = DATA_W'(op_addr);

  // ALU: one extra bit captures carry (ADD) or borrow (SUB)
  logic [DATA_W:0]   sum_full;
  logic [DATA_W:0]   diff_full;
  logic              alu_sub;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  assign sum_full   = {1'b0, acc_reg} + {1'b0, b_reg};
  assign diff_full  = {1'b0, acc_reg} - {1'b0, b_reg};
  assign alu_result = alu_sub ? diff_full[DATA_W-1:0] : sum_full[DATA_W-1:0];
  assign alu_carry  = alu_sub ? ~diff_full[DATA_W] : sum_full[DATA_W];

  // Control strobes decoded from the controller state and opcode
  logic              mar_from_pc;
  logic              mar_from_ir;
  logic              ir_load;
  logic              pc_inc;
  logic              pc_jump;
  logic              acc_from_ram;
  logic              acc_from_alu;
  logic              b_load;
  logic              ram_write;
  logic              out_load;
  logic              halt_set;
  logic [DATA_W-1:0] bus_val;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= T1;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mar_from_pc  = 1'b0;
    mar_from_ir  = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_jump      = 1'b0;
    acc_from_ram = 1'b0;
    acc_from_alu = 1'b0;
    alu_sub      = 1'b0;
    b_load       = 1'b0;
    ram_write    = 1'b0;
    out_load     = 1'b0;
    halt_set     = 1'b0;
    bus_val      = '0;

    // Once halted, the controller stops and nothing drives the bus
    if (!halted_reg) begin
      case (state_reg)
        T1: begin
          state_next  = T2;
          mar_from_pc = 1'b1;
          bus_val     = pc_ext;
        end
        T2: begin
          state_next = T3;
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          bus_val    = ram_q;
        end
        T3: begin
          state_next = T4;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_from_ir = 1'b1;
              bus_val     = addr_ext;
            end
            OP_JMP: begin
              pc_jump = 1'b1;
              bus_val = addr_ext;
            end
            OP_JZ: begin
              if (z_reg) begin
                pc_jump = 1'b1;
                bus_val = addr_ext;
              end
            end
            OP_OUT: begin
              out_load = 1'b1;
              bus_val  = acc_reg;
            end
            OP_HLT: begin
              halt_set = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          state_next = T5;
          case (opcode)
            OP_LDA: begin
              acc_from_ram = 1'b1;
              bus_val      = ram_q;
            end
            OP_ADD, OP_SUB: begin
              b_load  = 1'b1;
              bus_val = ram_q;
            end
            OP_STA: begin
              ram_write = 1'b1;
              bus_val   = acc_reg;
            end
            default: ;
          endcase
        end
        T5: begin
          state_next = T1;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            acc_from_alu = 1'b1;
            alu_sub      = (opcode == OP_SUB);
            bus_val      = alu_result;
          end
        end
        default: begin
          state_next = T1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_reg     <= '0;
      mar_reg    <= '0;
      ir_reg     <= '0;
      acc_reg    <= '0;
      b_reg      <= '0;
      out_reg    <= '0;
      c_reg      <= 1'b0;
      z_reg      <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      if (mar_from_pc) begin
        mar_reg <= pc_reg;
      end else if (mar_from_ir) begin
        mar_reg <= op_addr;
      end
      if (ir_load) begin
        ir_reg <= ram_q;
      end
      if (pc_inc) begin
        pc_reg <= pc_reg + ADDR_W'(1);
      end else if (pc_jump) begin
        pc_reg <= op_addr;
      end
      if (acc_from_ram) begin
        acc_reg <= ram_q;
      end else if (acc_from_alu) begin
        acc_reg <= alu_result;
        c_reg   <= alu_carry;
        z_reg   <= (alu_result == '0);
      end
      if (b_load) begin
        b_reg <= ram_q;
      end
      if (out_load) begin
        out_reg <= acc_reg;
      end
      if (halt_set) begin
        halted_reg <= 1'b1;
      end
    end
  end

  // RAM contents survive clr; the load port is only live while clr is high
  always_ff @(posedge clk) begin
    if (clr) begin
      if (prog_we) begin
        mem[prog_addr] <= prog_data;
      end
    end else if (ram_write) begin
      mem[mar_reg] <= acc_reg;
    end
  end

  assign out    = out_reg;
  assign bus    = bus_val;
  assign flags  = {c_reg, z_reg};
  assign halted = halted_reg;

endmodule

// File: tb/tb_sap_cpu_param.sv
// Directed bench for sap_cpu_param: table of per-cycle expectations for the
// 8-bit build, plus hand sequences for mid-instruction clr and a 12/8 build.
module tb_sap_cpu_param;

  logic        clk;
  logic        clr8, prog_we8;
  logic [3:0]  prog_addr8;
  logic [7:0]  prog_data8;
  logic [7:0]  out8, bus8;
  logic [1:0]  flags8;
  logic        halted8;

  logic        clr12, prog_we12;
  logic [7:0]  prog_addr12;
  logic [11:0] prog_data12;
  logic [11:0] out12, bus12;
  logic [1:0]  flags12;
  logic        halted12;

  int checks = 0;
  int errors = 0;
  int cyc8   = 0;
  int cyc12  = 0;

  sap_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .clr(clr8), .prog_we(prog_we8), .prog_addr(prog_addr8),
    .prog_data(prog_data8), .out(out8), .bus(bus8), .flags(flags8), .halted(halted8)
  );

  sap_cpu_param #(.DATA_W(12), .ADDR_W(8)) dut12 (
    .clk(clk), .clr(clr12), .prog_we(prog_we12), .prog_addr(prog_addr12),
    .prog_data(prog_data12), .out(out12), .bus(bus12), .flags(flags12), .halted(halted12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int         scen;
    int         cyc;
    logic [7:0] bus;
    logic [7:0] out;
    logic [1:0] flags;
    logic       halted;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] progs [6][16];
  logic [11:0] p12 [16];

  function automatic void add(int s, int c, logic [7:0] b, logic [7:0] o,
                              logic [1:0] f, logic h);
    vec_t v;
    v.scen = s; v.cyc = c; v.bus = b; v.out = o; v.flags = f; v.halted = h;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int cyc, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Loads progs[s] with clr held, then releases clr so the current cycle is cycle 1
  task automatic load8(int s);
    clr8 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      prog_we8   = 1'b1;
      prog_addr8 = 4'(a);
      prog_data8 = progs[s][a];
      @(posedge clk);
    end
    @(negedge clk);
    prog_we8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr8 = 1'b0;
    cyc8 = 1;
  endtask

  task automatic step8(int target);
    while (cyc8 < target) begin
      @(negedge clk);
      cyc8++;
    end
  endtask

  task automatic load12();
    clr12 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      prog_we12   = 1'b1;
      prog_addr12 = 8'(a);
      prog_data12 = p12[a];
      @(posedge clk);
    end
    @(negedge clk);
    prog_we12 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr12 = 1'b0;
    cyc12 = 1;
  endtask

  task automatic step12(int target);
    while (cyc12 < target) begin
      @(negedge clk);
      cyc12++;
    end
  endtask

  initial begin
    int cur;
    vec_t v;

    clr8 = 1'b1; prog_we8 = 1'b0; prog_addr8 = '0; prog_data8 = '0;
    clr12 = 1'b1; prog_we12 = 1'b0; prog_addr12 = '0; prog_data12 = '0;

    for (int s = 0; s < 6; s++)
      for (int a = 0; a < 16; a++)
        progs[s][a] = 8'h00;
    // 0: LDA 9, ADD A, OUT, HLT
    progs[0][0] = 8'h09; progs[0][1] = 8'h1A; progs[0][2] = 8'hE0; progs[0][3] = 8'hF0;
    progs[0][9] = 8'h05; progs[0][10] = 8'h03;
    // 1: LDA 9, SUB A, OUT, LDA 9, SUB 9, OUT, HLT
    progs[1][0] = 8'h09; progs[1][1] = 8'h2A; progs[1][2] = 8'hE0; progs[1][3] = 8'h09;
    progs[1][4] = 8'h29; progs[1][5] = 8'hE0; progs[1][6] = 8'hF0;
    progs[1][9] = 8'h02; progs[1][10] = 8'h03;
    // 2: LDA F, SUB F, JZ 0 with [F]=0
    progs[2][0] = 8'h0F; progs[2][1] = 8'h2F; progs[2][2] = 8'h60;
    // 3: sixteen NOPs
    for (int a = 0; a < 16; a++) progs[3][a] = 8'h70;
    // 4: LDA E, STA F, LDA F, OUT, HLT
    progs[4][0] = 8'h0E; progs[4][1] = 8'h4F; progs[4][2] = 8'h0F; progs[4][3] = 8'hE0;
    progs[4][4] = 8'hF0; progs[4][14] = 8'h5A;
    // 5: LDA E, OUT, ADD F, ADD F, OUT, HLT with [E]=[F]=0x80
    progs[5][0] = 8'h0E; progs[5][1] = 8'hE0; progs[5][2] = 8'h1F; progs[5][3] = 8'h1F;
    progs[5][4] = 8'hE0; progs[5][5] = 8'hF0; progs[5][14] = 8'h80; progs[5][15] = 8'h80;

    //    scen cyc  bus    out    flags  halted
    add(0,  1, 8'h00, 8'h00, 2'b00, 1'b0);
    add(0,  2, 8'h09, 8'h00, 2'b00, 1'b0);
    add(0,  3, 8'h09, 8'h00, 2'b00, 1'b0);
    add(0,  4, 8'h05, 8'h00, 2'b00, 1'b0);
    add(0,  5, 8'h00, 8'h00, 2'b00, 1'b0);
    add(0,  6, 8'h01, 8'h00, 2'b00, 1'b0);
    add(0,  7, 8'h1A, 8'h00, 2'b00, 1'b0);
    add(0,  8, 8'h0A, 8'h00, 2'b00, 1'b0);
    add(0,  9, 8'h03, 8'h00, 2'b00, 1'b0);
    add(0, 10, 8'h08, 8'h00, 2'b00, 1'b0);
    add(0, 11, 8'h02, 8'h00, 2'b00, 1'b0);
    add(0, 13, 8'h08, 8'h00, 2'b00, 1'b0);
    add(0, 14, 8'h00, 8'h08, 2'b00, 1'b0);
    add(0, 17, 8'hF0, 8'h08, 2'b00, 1'b0);
    add(0, 18, 8'h00, 8'h08, 2'b00, 1'b0);
    add(0, 19, 8'h00, 8'h08, 2'b00, 1'b1);
    add(0, 25, 8'h00, 8'h08, 2'b00, 1'b1);

    add(1,  1, 8'h00, 8'h00, 2'b00, 1'b0);
    add(1,  4, 8'h02, 8'h00, 2'b00, 1'b0);
    add(1,  9, 8'h03, 8'h00, 2'b00, 1'b0);
    add(1, 10, 8'hFF, 8'h00, 2'b00, 1'b0);
    add(1, 11, 8'h02, 8'h00, 2'b00, 1'b0);
    add(1, 14, 8'h00, 8'hFF, 2'b00, 1'b0);
    add(1, 19, 8'h02, 8'hFF, 2'b00, 1'b0);
    add(1, 24, 8'h02, 8'hFF, 2'b00, 1'b0);
    add(1, 25, 8'h00, 8'hFF, 2'b00, 1'b0);
    add(1, 26, 8'h05, 8'hFF, 2'b11, 1'b0);
    add(1, 28, 8'h00, 8'hFF, 2'b11, 1'b0);
    add(1, 29, 8'h00, 8'h00, 2'b11, 1'b0);
    add(1, 33, 8'h00, 8'h00, 2'b11, 1'b0);
    add(1, 34, 8'h00, 8'h00, 2'b11, 1'b1);

    add(2,  1, 8'h00, 8'h00, 2'b00, 1'b0);
    add(2,  2, 8'h0F, 8'h00, 2'b00, 1'b0);
    add(2,  7, 8'h2F, 8'h00, 2'b00, 1'b0);
    add(2, 10, 8'h00, 8'h00, 2'b00, 1'b0);
    add(2, 11, 8'h02, 8'h00, 2'b11, 1'b0);
    add(2, 13, 8'h00, 8'h00, 2'b11, 1'b0);
    add(2, 16, 8'h00, 8'h00, 2'b11, 1'b0);
    add(2, 17, 8'h0F, 8'h00, 2'b11, 1'b0);
    add(2, 21, 8'h01, 8'h00, 2'b11, 1'b0);
    add(2, 31, 8'h00, 8'h00, 2'b11, 1'b0);
    add(2, 32, 8'h0F, 8'h00, 2'b11, 1'b0);
    add(2, 46, 8'h00, 8'h00, 2'b11, 1'b0);

    add(3,  1, 8'h00, 8'h00, 2'b00, 1'b0);
    add(3,  2, 8'h70, 8'h00, 2'b00, 1'b0);
    add(3,  3, 8'h00, 8'h00, 2'b00, 1'b0);
    add(3, 76, 8'h0F, 8'h00, 2'b00, 1'b0);
    add(3, 77, 8'h70, 8'h00, 2'b00, 1'b0);
    add(3, 81, 8'h00, 8'h00, 2'b00, 1'b0);
    add(3, 86, 8'h01, 8'h00, 2'b00, 1'b0);

    add(4,  1, 8'h00, 8'h00, 2'b00, 1'b0);
    add(4,  4, 8'h5A, 8'h00, 2'b00, 1'b0);
    add(4,  8, 8'h0F, 8'h00, 2'b00, 1'b0);
    add(4,  9, 8'h5A, 8'h00, 2'b00, 1'b0);
    add(4, 14, 8'h5A, 8'h00, 2'b00, 1'b0);
    add(4, 18, 8'h5A, 8'h00, 2'b00, 1'b0);
    add(4, 19, 8'h00, 8'h5A, 2'b00, 1'b0);
    add(4, 23, 8'h00, 8'h5A, 2'b00, 1'b0);
    add(4, 24, 8'h00, 8'h5A, 2'b00, 1'b1);

    cur = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.scen != cur) begin
        load8(v.scen);
        cur = v.scen;
        // Runtime write attempt to a live data word; it must be ignored while clr=0
        if (cur <= 1) begin
          prog_we8 = 1'b1; prog_addr8 = 4'h9; prog_data8 = 8'h00;
        end
      end
      step8(v.cyc);
      $display("vec scen=%0d cycle=%0d bus=%h out=%h flags=%b halted=%b",
               v.scen, cyc8, bus8, out8, flags8, halted8);
      check($sformatf("s%0d_bus", v.scen), cyc8, 12'(bus8), 12'(v.bus));
      check($sformatf("s%0d_out", v.scen), cyc8, 12'(out8), 12'(v.out));
      check($sformatf("s%0d_flags", v.scen), cyc8, 12'(flags8), 12'(v.flags));
      check($sformatf("s%0d_halted", v.scen), cyc8, 12'(halted8), 12'(v.halted));
    end

    // clr asserted during T4 of an ADD, then the program reruns from address 0
    load8(5);
    check("clr_pre_halted", cyc8, 12'(halted8), 12'h0);
    step8(19);
    $display("seq clr_mid cycle=%0d bus=%h out=%h flags=%b", cyc8, bus8, out8, flags8);
    check("clr_pre_bus", cyc8, 12'(bus8), 12'h080);
    check("clr_pre_out", cyc8, 12'(out8), 12'h080);
    check("clr_pre_flags", cyc8, 12'(flags8), 12'h3);
    clr8 = 1'b1;
    @(negedge clk);
    $display("seq clr_post bus=%h out=%h flags=%b halted=%b", bus8, out8, flags8, halted8);
    check("clr_post_out", 0, 12'(out8), 12'h000);
    check("clr_post_flags", 0, 12'(flags8), 12'h0);
    check("clr_post_halted", 0, 12'(halted8), 12'h0);
    check("clr_post_bus", 0, 12'(bus8), 12'h000);
    clr8 = 1'b0;
    cyc8 = 1;
    step8(2);  check("rerun_bus_ir", cyc8, 12'(bus8), 12'h00E);
    step8(4);  check("rerun_bus_lda", cyc8, 12'(bus8), 12'h080);
    step8(9);  check("rerun_out", cyc8, 12'(out8), 12'h080);
    step8(16); check("rerun_flags_carry", cyc8, 12'(flags8), 12'h3);
    step8(21); check("rerun_flags_clear", cyc8, 12'(flags8), 12'h0);
    step8(28); check("rerun_not_halted", cyc8, 12'(halted8), 12'h0);
    step8(29); check("rerun_halted", cyc8, 12'(halted8), 12'h1);
    $display("seq rerun done cycle=%0d out=%h halted=%b", cyc8, out8, halted8);

    // 12-bit data, 8-bit address build
    for (int a = 0; a < 16; a++) p12[a] = 12'h000;
    p12[0] = 12'h009; p12[1] = 12'h10A; p12[2] = 12'hE00; p12[3] = 12'hF00;
    p12[9] = 12'h005; p12[10] = 12'h003;
    load12();
    step12(4);  check("w12_bus_lda", cyc12, bus12, 12'h005);
    step12(6);  check("w12_bus_pc", cyc12, bus12, 12'h001);
    step12(10); check("w12_bus_sum", cyc12, bus12, 12'h008);
    step12(14); check("w12_out", cyc12, out12, 12'h008);
    check("w12_flags", cyc12, 12'(flags12), 12'h0);
    step12(19); check("w12_halted", cyc12, 12'(halted12), 12'h1);
    $display("seq w12 cycle=%0d out=%h flags=%b halted=%b", cyc12, out12, flags12, halted12);

    p12[9] = 12'hFFF; p12[10] = 12'h001;
    load12();
    step12(4);  check("w12c_bus_lda", cyc12, bus12, 12'hFFF);
    step12(10); check("w12c_bus_sum", cyc12, bus12, 12'h000);
    step12(11); check("w12c_flags", cyc12, 12'(flags12), 12'h3);
    step12(14); check("w12c_out", cyc12, out12, 12'h000);
    step12(19); check("w12c_halted", cyc12, 12'(halted12), 12'h1);
    $display("seq w12c cycle=%0d out=%h flags=%b halted=%b", cyc12, out12, flags12, halted12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
